// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: walks the fetch offset, issues one I-cache read at a time,
// and presents fetched words to decode with valid/stall flow control, redirects and traps.
module ifetch_ctrl #(
    parameter int                     WORD_LENGTH    = 32,
    parameter int                     TIMEOUT_CYCLES = 64,
    parameter logic [WORD_LENGTH-1:0] RESET_OFS      = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   runEn,
    input  logic                   stallIn,
    input  logic                   redirValid,
    input  logic [WORD_LENGTH-1:0] redirOfs,
    output logic                   icReq,
    output logic [WORD_LENGTH-1:0] icAdr,
    input  logic                   icAck,
    input  logic [WORD_LENGTH-1:0] icData,
    output logic                   outValid,
    output logic [WORD_LENGTH-1:0] outInstr,
    output logic [WORD_LENGTH-1:0] outPstate1,
    output logic                   trapValid,
    output logic [1:0]             trapCode,
    input  logic                   trapClr
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, TRAP} state_t;

    localparam logic [1:0]             TRAP_NONE    = 2'b00;
    localparam logic [1:0]             TRAP_ALIGN   = 2'b01;
    localparam logic [1:0]             TRAP_TIMEOUT = 2'b10;
    localparam logic [7:0]             TO_LAST      = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [WORD_LENGTH-1:0] STEP         = WORD_LENGTH'(4);

    state_t                 state, state_n;
    logic [WORD_LENGTH-1:0] ofs, ofs_n;
    logic [WORD_LENGTH-1:0] pend_ofs, pend_ofs_n;
    logic                   pend, pend_n;
    logic [7:0]             cnt, cnt_n;
    logic [1:0]             code, code_n;
    logic [WORD_LENGTH-1:0] adr;
    logic                   ov_n;
    logic                   capture;
    logic                   misaligned;

    assign misaligned = (redirOfs[1:0] != 2'b00);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        ofs_n      = ofs;
        pend_n     = pend;
        pend_ofs_n = pend_ofs;
        cnt_n      = cnt;
        code_n     = code;
        capture    = 1'b0;
        ov_n       = outValid & stallIn;   // held only while decode refuses it

        if (state != TRAP && redirValid && misaligned) begin
            state_n = TRAP;
            code_n  = TRAP_ALIGN;
            ov_n    = 1'b0;
            pend_n  = 1'b0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (redirValid) begin
                        ofs_n   = redirOfs;
                        ov_n    = 1'b0;
                        state_n = runEn ? REQ : IDLE;
                    end else if (state == IDLE || !stallIn) begin
                        state_n = runEn ? REQ : IDLE;
                    end
                end
                REQ: begin
                    if (icAck) begin
                        cnt_n = '0;
                        // A redirect this cycle or one latched earlier squashes the returning word.
                        if (redirValid || pend) begin
                            ofs_n   = redirValid ? redirOfs : pend_ofs;
                            pend_n  = 1'b0;
                            ov_n    = 1'b0;
                            state_n = runEn ? REQ : IDLE;
                        end else begin
                            capture = 1'b1;
                            ov_n    = 1'b1;
                            ofs_n   = ofs + STEP;
                            state_n = stallIn ? HOLD : (runEn ? REQ : IDLE);
                        end
                    end else if (cnt == TO_LAST) begin
                        state_n = TRAP;
                        code_n  = TRAP_TIMEOUT;
                        ov_n    = 1'b0;
                        pend_n  = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                        if (redirValid) begin
                            pend_n     = 1'b1;
                            pend_ofs_n = redirOfs;
                            ov_n       = 1'b0;
                        end
                    end
                end
                TRAP: begin
                    ov_n = 1'b0;
                    if (trapClr) begin
                        state_n = IDLE;
                        code_n  = TRAP_NONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ofs        <= RESET_OFS;
            pend       <= 1'b0;
            pend_ofs   <= '0;
            cnt        <= '0;
            code       <= TRAP_NONE;
            adr        <= '0;
            outValid   <= 1'b0;
            outInstr   <= '0;
            outPstate1 <= '0;
        end else begin
            state    <= state_n;
            ofs      <= ofs_n;
            pend     <= pend_n;
            pend_ofs <= pend_ofs_n;
            cnt      <= cnt_n;
            code     <= code_n;
            outValid <= ov_n;
            if (state_n == REQ) adr <= ofs_n;   // stable while waiting, since ofs only moves on ack
            if (capture) begin
                outInstr   <= icData;
                outPstate1 <= adr;
            end
        end
    end

    assign icReq     = (state == REQ);
    assign icAdr     = adr;
    assign trapValid = (state == TRAP);
    assign trapCode  = code;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected fetch addresses and delivered words are queued
// by the stimulus and popped by independent monitors when the DUT acks or hands off a word.
module tb_ifetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0, rst = 1'b0;
    logic        runEn = 1'b0, stallIn = 1'b0, redirValid = 1'b0, trapClr = 1'b0;
    logic [31:0] redirOfs = '0;
    logic        icReq, icAck, outValid, trapValid;
    logic [31:0] icAdr, icData, outInstr, outPstate1;
    logic [1:0]  trapCode;

    logic        ack_en = 1'b0;
    int          ack_delay = 0;
    int          req_wait;
    int          checks = 0, errors = 0;
    logic [31:0] adr_q[$];
    logic [31:0] out_q[$];
    logic [31:0] exp_out;

    ifetch_ctrl #(.WORD_LENGTH(32), .TIMEOUT_CYCLES(8), .RESET_OFS(32'h100)) dut (
        .clk(clk), .rst(rst), .runEn(runEn), .stallIn(stallIn),
        .redirValid(redirValid), .redirOfs(redirOfs),
        .icReq(icReq), .icAdr(icAdr), .icAck(icAck), .icData(icData),
        .outValid(outValid), .outInstr(outInstr), .outPstate1(outPstate1),
        .trapValid(trapValid), .trapCode(trapCode), .trapClr(trapClr)
    );

    always #5 clk = ~clk;

    // Cache model: answers after ack_delay waiting cycles, data is address ^ KEY.
    assign icAck  = ack_en && icReq && (req_wait >= ack_delay);
    assign icData = icAdr ^ KEY;

    always @(posedge clk or negedge rst) begin
        if (!rst)                 req_wait <= 0;
        else if (icReq && !icAck) req_wait <= req_wait + 1;
        else                      req_wait <= 0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && icReq && icAck) begin
            if (adr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fetch_adr: got %h expected no fetch", icAdr);
            end else begin
                check("fetch_adr", icAdr, adr_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && outValid && !stallIn) begin
            if (out_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_word: got %h expected no output", outPstate1);
            end else begin
                exp_out = out_q.pop_front();
                check("out_pstate1", outPstate1, exp_out);
                check("out_instr", outInstr, exp_out ^ KEY);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int guard;

        // Reset state
        tick(); tick();
        check("rst_icReq", 32'(icReq), 32'd0);
        check("rst_icAdr", icAdr, 32'h0);
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outInstr", outInstr, 32'h0);
        check("rst_outPstate1", outPstate1, 32'h0);
        check("rst_trap", {29'd0, trapValid, trapCode}, 32'd0);

        // Back-to-back fetch from RESET_OFS
        adr_q = '{32'h100, 32'h104, 32'h108};
        out_q = '{32'h100, 32'h104, 32'h108};
        rst = 1'b1; runEn = 1'b1; ack_en = 1'b1; ack_delay = 0;
        tick(); check("b2b_adr0", icAdr, 32'h100); check("b2b_req0", 32'(icReq), 32'd1);
        tick(); check("b2b_adr1", icAdr, 32'h104); check("b2b_ps0", outPstate1, 32'h100);
        tick(); check("b2b_adr2", icAdr, 32'h108);
        runEn = 1'b0;
        tick(); check("b2b_idle", 32'(icReq), 32'd0); check("b2b_ps2", outPstate1, 32'h108);
        tick(); check("b2b_consumed", 32'(outValid), 32'd0);

        // Stall on capture: HOLD with frozen outputs, next fetch after stall falls
        adr_q.push_back(32'h10C); adr_q.push_back(32'h110);
        out_q.push_back(32'h10C); out_q.push_back(32'h110);
        runEn = 1'b1; stallIn = 1'b1;
        tick(); check("stall_adr", icAdr, 32'h10C);
        tick(); check("stall_req0", 32'(icReq), 32'd0); check("stall_ps0", outPstate1, 32'h10C);
        check("stall_valid", 32'(outValid), 32'd1);
        tick(); check("stall_req1", 32'(icReq), 32'd0); check("stall_ps1", outPstate1, 32'h10C);
        tick(); check("stall_req2", 32'(icReq), 32'd0); check("stall_instr", outInstr, 32'h10C ^ KEY);
        stallIn = 1'b0;
        tick(); check("unstall_req", 32'(icReq), 32'd1); check("unstall_adr", icAdr, 32'h110);
        runEn = 1'b0;
        tick(); check("unstall_idle", 32'(icReq), 32'd0);
        tick();

        // Redirect while a request waits; second redirect overwrites the first
        adr_q.push_back(32'h114); adr_q.push_back(32'h2000);
        out_q.push_back(32'h2000);
        ack_delay = 4; runEn = 1'b1;
        tick(); check("pend_adr0", icAdr, 32'h114);
        redirValid = 1'b1; redirOfs = 32'h1000;
        tick();
        redirOfs = 32'h2000;
        tick();
        redirValid = 1'b0;
        check("pend_hold_adr", icAdr, 32'h114); check("pend_ov", 32'(outValid), 32'd0);
        tick(); check("pend_hold_adr2", icAdr, 32'h114);
        tick();
        tick(); check("pend_new_adr", icAdr, 32'h2000); check("pend_squash", 32'(outValid), 32'd0);
        runEn = 1'b0;
        repeat (6) tick();
        check("pend_idle", 32'(icReq), 32'd0); check("pend_ps", outPstate1, 32'h2000);

        // Misaligned redirect traps; redirects ignored in TRAP; fetch resumes at old offset
        ack_delay = 0;
        redirValid = 1'b1; redirOfs = 32'h2002;
        tick();
        check("align_trap", 32'(trapValid), 32'd1); check("align_code", 32'(trapCode), 32'd1);
        check("align_req", 32'(icReq), 32'd0);
        redirOfs = 32'h3000;
        tick();
        redirValid = 1'b0;
        check("align_ignore", 32'(trapValid), 32'd1);
        trapClr = 1'b1;
        tick();
        trapClr = 1'b0;
        check("align_clr", {29'd0, trapValid, trapCode}, 32'd0);
        adr_q.push_back(32'h2004); out_q.push_back(32'h2004);
        runEn = 1'b1;
        tick(); check("align_resume", icAdr, 32'h2004);
        runEn = 1'b0;
        tick(); tick();

        // Offset wraps at the top of the address space without trapping
        adr_q.push_back(32'hFFFF_FFFC); adr_q.push_back(32'h0);
        out_q.push_back(32'hFFFF_FFFC); out_q.push_back(32'h0);
        redirValid = 1'b1; redirOfs = 32'hFFFF_FFFC; runEn = 1'b1;
        tick();
        redirValid = 1'b0;
        check("wrap_adr0", icAdr, 32'hFFFF_FFFC);
        tick(); check("wrap_adr1", icAdr, 32'h0); check("wrap_notrap", 32'(trapValid), 32'd0);
        runEn = 1'b0;
        tick(); tick();

        // Cache timeout after TIMEOUT_CYCLES request cycles, then reset mid-request
        ack_en = 1'b0; runEn = 1'b1;
        n = 0; guard = 0;
        tick();
        while (!trapValid && guard < 40) begin
            if (icReq) n++;
            tick();
            guard++;
        end
        check("to_cycles", 32'(n), 32'd8);
        check("to_trap", 32'(trapValid), 32'd1); check("to_code", 32'(trapCode), 32'd2);
        check("to_req", 32'(icReq), 32'd0);
        trapClr = 1'b1;
        tick();
        trapClr = 1'b0;
        tick(); tick();
        check("mid_req", 32'(icReq), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mrst_req", 32'(icReq), 32'd0); check("mrst_adr", icAdr, 32'h0);
        check("mrst_ov", 32'(outValid), 32'd0); check("mrst_instr", outInstr, 32'h0);
        check("mrst_ps", outPstate1, 32'h0);
        check("mrst_trap", {29'd0, trapValid, trapCode}, 32'd0);
        runEn = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();

        check("adr_q_drained", 32'(adr_q.size()), 32'd0);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
